// File: rtl/nios2_multi_timer.sv
// nios2_multi_timer
// NUM_CH independent down-counting interval timers behind a single Avalon-MM
// slave, intended as a Nios II data-master peripheral.
//
// Ports
//   clk         system clock (single domain)
//   reset       asynchronous, active-high reset
//   address     {channel, reg[1:0]}; reg 0 STATUS, 1 CONTROL, 2 PERIOD, 3 SNAP
//   chipselect  slave select
//   write_n     active-low write strobe
//   writedata   32-bit write data
//   readdata    registered read data (1-cycle latency from address)
//   irq         per-channel level interrupt (TO & ITO)
//   irq_any     OR of all irq bits
//
// Optional feature: define NIOS2_MULTI_TIMER_PRESCALE_EN to give every channel
// a 16-bit prescaler so the counter advances once every 2^PS clocks. Without
// it the counter advances every clock and the PS field reads 0.

module nios2_multi_timer #(
    parameter int NUM_CH       = 4,
    parameter int COUNT_W      = 32,
    parameter int RESET_PERIOD = 49999
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [$clog2(NUM_CH)+1:0]   address,
    input  logic                        chipselect,
    input  logic                        write_n,
    input  logic [31:0]                 writedata,
    output logic [31:0]                 readdata,
    output logic [NUM_CH-1:0]           irq,
    output logic                        irq_any
);

    localparam int AW = $clog2(NUM_CH) + 2;
    localparam logic [COUNT_W-1:0] RST_CNT = COUNT_W'(RESET_PERIOD);

    logic          wr;
    logic [1:0]    reg_sel;
    logic [AW-1:0] ch_addr;

    assign wr      = chipselect & ~write_n;
    assign reg_sel = address[1:0];
    assign ch_addr = address >> 2;

    // Per-channel read views, gathered by the read mux below.
    logic [NUM_CH-1:0][31:0] ch_status;
    logic [NUM_CH-1:0][31:0] ch_control;
    logic [NUM_CH-1:0][31:0] ch_period;
    logic [NUM_CH-1:0][31:0] ch_snap;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        localparam logic [AW-1:0] CH_ID = AW'(i);

        logic [COUNT_W-1:0] counter_q, counter_d;
        logic [COUNT_W-1:0] period_q, period_d;
        logic [COUNT_W-1:0] snap_q, snap_d;
        logic               run_q, run_d;
        logic               to_q, to_d;
        logic               ito_q, ito_d;
        logic               cont_q, cont_d;
        logic               force_reload_q, force_reload_d;
        logic               zero_prev_q, zero_prev_d;
        logic               sel, start, stop, cnt_zero, tick, timeout_event;
        logic [3:0]         ps_rd;

        assign sel      = wr && (ch_addr == CH_ID);
        assign start    = sel && (reg_sel == 2'd1) && writedata[2];
        assign stop     = sel && (reg_sel == 2'd1) && writedata[3];
        assign cnt_zero = (counter_q == '0);
        // Timeout fires on the cycle the counter first reads zero, so a
        // zero period produces one timeout rather than one per cycle.
        assign timeout_event = cnt_zero & ~zero_prev_q;

`ifdef NIOS2_MULTI_TIMER_PRESCALE_EN
        logic [3:0]  ps_q, ps_d;
        logic [15:0] presc_q, presc_d;
        logic [15:0] presc_mask;

        // Tick when the low PS bits of the free-running prescaler are all ones.
        assign presc_mask = (16'd1 << ps_q) - 16'd1;
        assign tick       = ((presc_q & presc_mask) == presc_mask);
        assign ps_rd      = ps_q;

        always_comb begin
            ps_d    = ps_q;
            presc_d = presc_q + 16'd1;
            if (start || force_reload_q) begin
                presc_d = '0;
            end
            if (sel && (reg_sel == 2'd1)) begin
                ps_d = writedata[11:8];
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                ps_q    <= '0;
                presc_q <= '0;
            end else begin
                ps_q    <= ps_d;
                presc_q <= presc_d;
            end
        end
`else
        assign tick  = 1'b1;
        assign ps_rd = 4'd0;
`endif

        always_comb begin
            counter_d      = counter_q;
            period_d       = period_q;
            snap_d         = snap_q;
            run_d          = run_q;
            to_d           = to_q;
            ito_d          = ito_q;
            cont_d         = cont_q;
            force_reload_d = 1'b0;
            zero_prev_d    = cnt_zero;

            if (force_reload_q) begin
                counter_d = period_q;
            end else if (run_q && tick && cnt_zero) begin
                counter_d = period_q;
            end else if (run_q && tick) begin
                counter_d = counter_q - 1'b1;
            end

            // START overrides every reason to stop in the same cycle.
            if (start) begin
                run_d = 1'b1;
            end else if (stop || force_reload_q || (cnt_zero && tick && !cont_q)) begin
                run_d = 1'b0;
            end

            // A STATUS write beats a coincident timeout.
            if (sel && (reg_sel == 2'd0)) begin
                to_d = 1'b0;
            end else if (timeout_event) begin
                to_d = 1'b1;
            end

            if (sel && (reg_sel == 2'd1)) begin
                ito_d  = writedata[0];
                cont_d = writedata[1];
            end

            if (sel && (reg_sel == 2'd2)) begin
                period_d       = writedata[COUNT_W-1:0];
                force_reload_d = 1'b1;
            end

            if (sel && (reg_sel == 2'd3)) begin
                snap_d = counter_q;
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                counter_q      <= RST_CNT;
                period_q       <= RST_CNT;
                snap_q         <= '0;
                run_q          <= 1'b0;
                to_q           <= 1'b0;
                ito_q          <= 1'b0;
                cont_q         <= 1'b0;
                force_reload_q <= 1'b0;
                zero_prev_q    <= 1'b0;
            end else begin
                counter_q      <= counter_d;
                period_q       <= period_d;
                snap_q         <= snap_d;
                run_q          <= run_d;
                to_q           <= to_d;
                ito_q          <= ito_d;
                cont_q         <= cont_d;
                force_reload_q <= force_reload_d;
                zero_prev_q    <= zero_prev_d;
            end
        end

        assign ch_status[i]  = {30'd0, run_q, to_q};
        assign ch_control[i] = {20'd0, ps_rd, 6'd0, cont_q, ito_q};
        assign ch_period[i]  = 32'(period_q);
        assign ch_snap[i]    = 32'(snap_q);
        assign irq[i]        = to_q & ito_q;
    end

    assign irq_any = |irq;

    // Read mux; addresses beyond the last channel read 0.
    logic [31:0] readdata_q, readdata_d;

    always_comb begin
        readdata_d = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (ch_addr == AW'(k)) begin
                case (reg_sel)
                    2'd0:    readdata_d = ch_status[k];
                    2'd1:    readdata_d = ch_control[k];
                    2'd2:    readdata_d = ch_period[k];
                    default: readdata_d = ch_snap[k];
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata_q <= '0;
        end else begin
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;

endmodule

// File: tb/tb_nios2_multi_timer.sv
// Testbench for nios2_multi_timer (default parameters: 4 channels, 32-bit).
// Reads push their expected readdata (and optionally irq) into a queue; a
// monitor pops and compares when the registered read data becomes valid.

module tb_nios2_multi_timer;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [3:0]  irq;
    logic        irq_any;

    nios2_multi_timer #(
        .NUM_CH(4),
        .COUNT_W(32),
        .RESET_PERIOD(49999)
    ) dut (
        .clk(clk),
        .reset(reset),
        .address(address),
        .chipselect(chipselect),
        .write_n(write_n),
        .writedata(writedata),
        .readdata(readdata),
        .irq(irq),
        .irq_any(irq_any)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] rd;
        logic        chk_irq;
        logic [3:0]  irq;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   vec_count   = 0;
    int   miscompares = 0;
    logic rd_req      = 1'b0;
    logic rd_valid    = 1'b0;

    // Read data is valid the cycle after the read was presented.
    always @(posedge clk) rd_valid <= rd_req;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_count++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: compares whenever the DUT presents read data.
    always @(negedge clk) begin
        if (rd_valid) begin
            if (exp_q.size() == 0) begin
                vec_count++;
                miscompares++;
                $display("[TB] FAIL unexpected_read: got 0x%08h, expected no data", readdata);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput(mon_e.name, readdata, mon_e.rd);
                if (mon_e.chk_irq) begin
                    checkOutput({mon_e.name, "_irq"}, 32'(irq), 32'(mon_e.irq));
                    checkOutput({mon_e.name, "_irq_any"}, 32'(irq_any), 32'(|mon_e.irq));
                end
            end
        end
    end

    // One bus cycle; returns one time unit after the closing clock edge.
    task automatic applyStimulus(input logic is_write, input int ch, input int rg, input logic [31:0] data);
        address    = 4'((ch << 2) | rg);
        chipselect = 1'b1;
        write_n    = ~is_write;
        writedata  = data;
        rd_req     = ~is_write;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        rd_req     = 1'b0;
    endtask

    task automatic wr_reg(input int ch, input int rg, input logic [31:0] data);
        applyStimulus(1'b1, ch, rg, data);
    endtask

    task automatic rd_reg(input string name, input int ch, input int rg, input logic [31:0] exp,
                          input logic chk_irq = 1'b0, input logic [3:0] exp_irq = 4'd0);
        exp_q.push_back('{name, exp, chk_irq, exp_irq});
        applyStimulus(1'b0, ch, rg, 32'd0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int budget;
        budget = 20;
        while (exp_q.size() != 0 && budget > 0) begin
            @(posedge clk);
            #1;
            budget--;
        end
        if (exp_q.size() != 0) begin
            vec_count++;
            miscompares++;
            $display("[TB] FAIL drain_timeout: got %0d pending reads, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset      = 1'b1;
        address    = '0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_readdata", readdata, 32'd0);
        checkOutput("rst_irq", 32'(irq), 32'd0);
        checkOutput("rst_irq_any", 32'(irq_any), 32'd0);
        reset = 1'b0;

        // Reset values
        rd_reg("ch0_period_rst", 0, 2, 32'd49999);
        rd_reg("ch0_status_rst", 0, 0, 32'd0, 1'b1, 4'b0000);
        rd_reg("ch0_control_rst", 0, 1, 32'd0);
        rd_reg("ch3_snap_rst", 3, 3, 32'd0);

        // Ch1 continuous, period 5: timeout every 6 clocks
        wr_reg(1, 2, 32'd5);
        wr_reg(1, 1, 32'h7);
        idle(5);
        rd_reg("ch1_before_to", 1, 0, 32'h2);
        rd_reg("ch1_to", 1, 0, 32'h3, 1'b1, 4'b0010);
        wr_reg(1, 0, 32'd0);
        rd_reg("ch1_to_cleared", 1, 0, 32'h2, 1'b1, 4'b0000);
        idle(2);
        rd_reg("ch1_before_to2", 1, 0, 32'h2);
        rd_reg("ch1_to2", 1, 0, 32'h3, 1'b1, 4'b0010);
        wr_reg(1, 1, 32'h8);
        wr_reg(1, 0, 32'd0);
        rd_reg("ch1_control_stopped", 1, 1, 32'd0);

        // Ch2 one-shot, period 3
        wr_reg(2, 2, 32'd3);
        wr_reg(2, 1, 32'h5);
        idle(3);
        rd_reg("ch2_running", 2, 0, 32'h2);
        rd_reg("ch2_oneshot_to", 2, 0, 32'h1, 1'b1, 4'b0100);
        wr_reg(2, 3, 32'd0);
        rd_reg("ch2_snap_reload", 2, 3, 32'd3);
        idle(4);
        wr_reg(2, 3, 32'd0);
        rd_reg("ch2_snap_hold", 2, 3, 32'd3);
        wr_reg(2, 0, 32'd0);

        // Ch0 running from reset count, then PERIOD write stops it
        wr_reg(0, 1, 32'h4);
        idle(1);
        wr_reg(0, 3, 32'd0);
        rd_reg("ch0_snap_running", 0, 3, 32'd49998);
        wr_reg(0, 2, 32'd10);
        rd_reg("ch0_run_before_reload", 0, 0, 32'h2);
        rd_reg("ch0_stopped_by_period", 0, 0, 32'h0);
        wr_reg(0, 3, 32'd0);
        rd_reg("ch0_snap_reloaded", 0, 3, 32'd10);
        rd_reg("ch0_period_10", 0, 2, 32'd10);

        // START and STOP together: START wins; strobes read 0
        wr_reg(3, 1, 32'hC);
        rd_reg("ch3_start_wins", 3, 0, 32'h2);
        rd_reg("ch3_strobes_read0", 3, 1, 32'h0);

        // Timeout coinciding with a STATUS write stays cleared
        wr_reg(3, 2, 32'd2);
        wr_reg(3, 1, 32'h7);
        idle(2);
        wr_reg(3, 0, 32'd0);
        rd_reg("ch3_to_suppressed", 3, 0, 32'h2, 1'b1, 4'b0000);
        idle(2);
        rd_reg("ch3_next_to", 3, 0, 32'h3);
        wr_reg(3, 1, 32'h8);
        wr_reg(3, 0, 32'd0);

        // Ch1 with PERIOD 0 while running: TO fires once
        wr_reg(1, 2, 32'd0);
        wr_reg(1, 1, 32'h6);
        idle(1);
        rd_reg("ch1_zero_period_to", 1, 0, 32'h3);
        wr_reg(1, 0, 32'd0);
        idle(2);
        rd_reg("ch1_zero_period_once", 1, 0, 32'h2);
        wr_reg(1, 3, 32'd0);
        rd_reg("ch1_snap_zero", 1, 3, 32'd0);
        wr_reg(1, 1, 32'h8);

        // Prescale field and PERIOD=1 timing
        wr_reg(2, 1, 32'h203);
`ifdef NIOS2_MULTI_TIMER_PRESCALE_EN
        rd_reg("ch2_ps_stored", 2, 1, 32'h203);
        wr_reg(0, 2, 32'd1);
        wr_reg(0, 1, 32'h204);
        idle(12);
        rd_reg("ch0_ps_oneshot_done", 0, 0, 32'h1);
`else
        rd_reg("ch2_ps_reads0", 2, 1, 32'h3);
        wr_reg(0, 2, 32'd1);
        wr_reg(0, 1, 32'h4);
        idle(1);
        rd_reg("ch0_period1_before_to", 0, 0, 32'h2);
        rd_reg("ch0_period1_to", 0, 0, 32'h1, 1'b1, 4'b0000);
`endif

        // irq on ch0, then asynchronous reset mid-cycle
        wr_reg(0, 1, 32'h1);
        rd_reg("ch0_irq_set", 0, 0, 32'h1, 1'b1, 4'b0001);
        wr_reg(3, 1, 32'h6);
        drain();
        #2;
        reset = 1'b1;
        #1;
        checkOutput("rst_mid_readdata", readdata, 32'd0);
        checkOutput("rst_mid_irq", 32'(irq), 32'd0);
        checkOutput("rst_mid_irq_any", 32'(irq_any), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        rd_reg("ch0_status_after_rst", 0, 0, 32'h0, 1'b1, 4'b0000);
        rd_reg("ch3_status_after_rst", 3, 0, 32'h0);
        rd_reg("ch3_period_after_rst", 3, 2, 32'd49999);
        rd_reg("ch0_control_after_rst", 0, 1, 32'h0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule
